// File: rtl/ultrasonic_pkg.sv
// Shared types and cycle-conversion helpers for the ultrasonic ranger.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    // Microseconds to clock cycles, computed wide to avoid overflow.
    function automatic int us_to_cycles(input int clk_hz, input int us);
        longint c;
        c = longint'(clk_hz) * longint'(us) / longint'(1_000_000);
        return int'(c);
    endfunction

    // Milliseconds to clock cycles, computed wide to avoid overflow.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        longint c;
        c = longint'(clk_hz) * longint'(ms) / longint'(1_000);
        return int'(c);
    endfunction

    // Binary constant to packed BCD, up to eight digits.
    function automatic logic [31:0] bin_to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_bcd_counter.sv
// Multi-digit BCD up-counter with clear and a look-ahead compare against a constant.
module bcd_counter
    import ultrasonic_pkg::*;
#(
    parameter int DIGITS  = 3,
    parameter int CMP_VAL = 400
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   q,
    output logic                  next_eq
);

    localparam logic [31:0]         CMP_ALL = bin_to_bcd(CMP_VAL);
    localparam logic [4*DIGITS-1:0] CMP_BCD = CMP_ALL[4*DIGITS-1:0];

    logic [4*DIGITS-1:0] q_inc;
    logic                carry;

    // Decimal ripple increment: each digit rolls 9 -> 0 and carries upward.
    always_comb begin
        q_inc = q;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (q[4*i +: 4] == 4'd9) begin
                    q_inc[4*i +: 4] = 4'd0;
                end else begin
                    q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    // High when the pending increment would land exactly on the constant.
    assign next_eq = (q_inc == CMP_BCD);

    // Count register: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= q_inc;
        end
    end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Periodic HC-SR04-style trigger and echo timer reporting distance in BCD centimetres.
module ultrasonic_ranger
    import ultrasonic_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TRIG_US     = 10,
    parameter int CYC_PER_CM  = CLK_HZ / 1_000_000 * 58,
    parameter int MAX_CM      = 400,
    parameter int RISE_TMO_US = 1000,
    parameter int PERIOD_MS   = 60,
    parameter int DIGITS      = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                echo,
    output logic                trig,
    output logic [4*DIGITS-1:0] dist_bcd,
    output logic                dist_valid,
    output logic                timeout,
    output logic                busy
);

    localparam int TRIG_CYC   = us_to_cycles(CLK_HZ, TRIG_US);
    localparam int RISE_CYC   = us_to_cycles(CLK_HZ, RISE_TMO_US);
    localparam int PERIOD_CYC = ms_to_cycles(CLK_HZ, PERIOD_MS);
    localparam int TMR_MAX    = (TRIG_CYC > RISE_CYC) ? TRIG_CYC : RISE_CYC;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);
    localparam int PRESC_W    = $clog2(CYC_PER_CM + 1);
    localparam int PERIOD_W   = $clog2(PERIOD_CYC + 1);

    localparam logic [TMR_W-1:0]    TRIG_LAST   = TMR_W'(TRIG_CYC - 1);
    localparam logic [TMR_W-1:0]    RISE_LAST   = TMR_W'(RISE_CYC - 1);
    localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(CYC_PER_CM - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_CYC - 1);

    if (PERIOD_CYC <= TRIG_CYC + RISE_CYC + MAX_CM * CYC_PER_CM) begin : g_bad_period
        $error("ultrasonic_ranger: period too short for trigger, rise timeout and full range");
    end
    if (MAX_CM >= 10 ** DIGITS) begin : g_bad_digits
        $error("ultrasonic_ranger: MAX_CM does not fit in DIGITS BCD digits");
    end

    state_t                state;
    logic                  echo_p0;
    logic                  echo_p1;
    logic                  echo_p2;
    logic                  rise;
    logic                  fall;
    logic [TMR_W-1:0]      tmr_cnt;
    logic [PRESC_W-1:0]    presc_cnt;
    logic [PERIOD_W-1:0]   period_cnt;
    logic                  presc_wrap;
    logic                  period_done;
    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  cnt_at_max;
    logic [4*DIGITS-1:0]   cnt_q;

    // Two-flop synchroniser for the asynchronous echo pin, plus one history flop for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_p0 <= 1'b0;
            echo_p1 <= 1'b0;
            echo_p2 <= 1'b0;
        end else begin
            echo_p0 <= echo;
            echo_p1 <= echo_p0;
            echo_p2 <= echo_p1;
        end
    end

    assign rise        = echo_p1 & ~echo_p2;
    assign fall        = ~echo_p1 & echo_p2;
    assign presc_wrap  = (presc_cnt == PRESC_LAST);
    assign period_done = (period_cnt >= PERIOD_LAST);
    assign cnt_clr     = (state == WAIT_RISE) && rise;
    assign cnt_inc     = (state == MEASURE) && presc_wrap;
    assign busy        = (state != IDLE);

    bcd_counter #(
        .DIGITS  (DIGITS),
        .CMP_VAL (MAX_CM)
    ) u_cm_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .q       (cnt_q),
        .next_eq (cnt_at_max)
    );

    // Measurement sequencer with registered trigger, result and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            trig       <= 1'b0;
            dist_bcd   <= '0;
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
            tmr_cnt    <= '0;
            presc_cnt  <= '0;
            period_cnt <= '0;
        end else begin
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
            tmr_cnt    <= '0;
            presc_cnt  <= '0;
            period_cnt <= (state == IDLE) ? '0 : period_cnt + 1'b1;
            // Losing enable abandons an in-flight measurement silently; HOLDOFF finishes its period.
            if (!enable && (state inside {TRIG, WAIT_RISE, MEASURE})) begin
                state <= IDLE;
                trig  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (enable) begin
                            state      <= TRIG;
                            trig       <= 1'b1;
                            period_cnt <= '0;
                        end
                    end
                    TRIG: begin
                        if (tmr_cnt == TRIG_LAST) begin
                            state <= WAIT_RISE;
                            trig  <= 1'b0;
                        end else begin
                            tmr_cnt <= tmr_cnt + 1'b1;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            state <= MEASURE;
                        end else if (tmr_cnt == RISE_LAST) begin
                            timeout <= 1'b1;
                            state   <= HOLDOFF;
                        end else begin
                            tmr_cnt <= tmr_cnt + 1'b1;
                        end
                    end
                    MEASURE: begin
                        presc_cnt <= presc_wrap ? '0 : presc_cnt + 1'b1;
                        // A fall in the same cycle as the range limit still reports a distance.
                        if (fall) begin
                            dist_bcd   <= cnt_q;
                            dist_valid <= 1'b1;
                            state      <= HOLDOFF;
                        end else if (cnt_inc && cnt_at_max) begin
                            timeout <= 1'b1;
                            state   <= HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        if (period_done) begin
                            period_cnt <= '0;
                            if (enable) begin
                                state <= TRIG;
                                trig  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        trig  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
